float_mul_pipe: RTL and testbench
=================================

// Module: float_mul_pipe
// PURPOSE
//  Parametrised, pipelined IEEE-754-style floating-point multiplier; successor to float_mul.
//  Adds configurable exponent/mantissa widths, a valid/ready handshake with backpressure,
//  synchronous reset and round-to-nearest-even. Sits between operand producers and the FPU
//  result bus; one multiply accepted per cycle when not stalled.
// PARAMETERS
//  EXP_W   8    exponent field width (bias = 2^(EXP_W-1)-1)
//  MAN_W   23   stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   synchronous reset, active low
//  in_valid   in   1   v1/v2 carry an operand pair
//  in_ready   out  1   block can accept the pair this cycle
//  v1         in   W   operand A {sign, exp, frac}
//  v2         in   W   operand B
//  out_valid  out  1   vres holds a result
//  out_ready  in   1   consumer accepts vres this cycle
//  vres       out  W   product
//  flags      out  5   {invalid, overflow, underflow, inexact, zero}; only with FLOAT_MUL_FLAGS_EN
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all stage valid bits, out_valid, vres and flags -> 0. In-flight ops discarded.
//  Pipeline, 3 registered stages, latency 3 cycles from accepted input to out_valid:
//   S1 unpack, classify (zero/sub/inf/nan), sign = s1^s2, exp sum e1+e2-bias in EXP_W+2 signed bits
//   S2 (MAN_W+1)x(MAN_W+1) mantissa product, 2*MAN_W+2 bits
//   S3 normalise (shift 1 if product MSB set, exp+1), round-to-nearest-even on guard/sticky,
//      renormalise on rounding carry, overflow/underflow clamp, pack
//  Handshake: advance = !out_valid | out_ready; in_ready = advance (combinational).
//   Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
//   advance=0 freezes all stages (global stall); bubbles are not collapsed.
//   out_valid/vres stay stable while out_valid & !out_ready.
//   Simultaneous in-accept and out-accept in the same cycle is legal: full throughput.
//  Special cases (decided in S1, carried as a flag to S3, override arithmetic):
//   subnormal input -> treated as signed zero (flush-to-zero)
//   NaN either input, or inf*zero -> canonical quiet NaN {0, all-1 exp, 1 then zeros}
//   inf*nonzero -> signed inf; zero*finite -> signed zero
//  Result ranges: biased exp >= 2^EXP_W-1 after rounding -> signed inf;
//   biased exp <= 0 -> signed zero (no subnormal outputs).
//  Rounding carry into all-ones exponent yields inf (overflow).
// CONFIGURATION
//  FLOAT_MUL_FLAGS_EN defined: flags port exists, registered alongside vres, same valid/stall rules;
//   invalid=NaN created from inf*0 or NaN input, overflow=clamped to inf from finite inputs,
//   underflow=nonzero exact result flushed to zero, inexact=discarded bits nonzero or over/underflow,
//   zero=vres is +/-0. Reset to 0.
//  Not defined: flags port and its logic absent; datapath behaviour identical.
// TESTING (EXP_W=8, MAN_W=23 unless noted)
//  40E80000 (7.25) * 40000000 (2.0) -> vres 41680000 (14.5), out_valid exactly 3 cycles after accept
//  C0000000 * 40400000 -> C0C00000; 3F800001 * 3F800001 -> 3F800002 (RNE), inexact=1
//  7F800000 * 00000000 -> 7FC00000, invalid=1; 7F7FFFFF * 40000000 -> 7F800000, overflow=1;
//   00800000 * 3F000000 -> 00000000, underflow=1, zero=1
//  Back-to-back 8 ops with out_ready low cycles 2-5 -> in_ready low while stalled, results in order,
//   none lost/duplicated, vres stable during stall
//  rst_n low for 1 cycle with 2 ops in flight -> out_valid 0 next cycle, no stale results emerge after
//  EXP_W=5, MAN_W=10 (half): 3C00 (1.0) * 4000 (2.0) -> 4000; 7BFF * 4000 -> 7C00

Source files
------------

// File: rtl/float_mul_pipe.sv
// float_mul_pipe: three-stage IEEE-754-style floating-point multiplier.
// Parametrised exponent/mantissa widths, valid/ready handshake with a global
// stall, flush-to-zero on subnormals, round-to-nearest-even and no subnormal
// outputs. Optional exception flags port is enabled by FLOAT_MUL_FLAGS_EN.
module float_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] v1,
  input  logic [EXP_W+MAN_W:0] v2,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef FLOAT_MUL_FLAGS_EN
  output logic [4:0]           flags,
`endif
  output logic [EXP_W+MAN_W:0] vres
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int EW2 = EXP_W + 2;
  localparam int PW  = 2 * MAN_W + 2;

  localparam logic signed [EW2-1:0] BIAS_X = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EMAX_X = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] ZERO_X = '0;

  // Operand-pair class decided up front; anything but CLS_NORM overrides the arithmetic.
  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

  function automatic logic [MAN_W:0] rne_round(input logic [MAN_W-1:0] frac,
                                               input logic guard,
                                               input logic sticky);
    logic up;
    up = guard & (sticky | frac[0]);
    return {1'b0, frac} + {{MAN_W{1'b0}}, up};
  endfunction

  function automatic logic [W-1:0] pack_result(input cls_e cls,
                                               input logic sign,
                                               input logic signed [EW2-1:0] e,
                                               input logic [MAN_W-1:0] frac);
    logic [W-1:0] r;
    case (cls)
      CLS_NAN:  r = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      CLS_INF:  r = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: r = {sign, {(W-1){1'b0}}};
      default: begin
        if (e >= EMAX_X)      r = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (e <= ZERO_X) r = {sign, {(W-1){1'b0}}};
        else                  r = {sign, e[EXP_W-1:0], frac};
      end
    endcase
    return r;
  endfunction

  logic advance;

  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  logic                  vld_p1_d, vld_p1_q;
  logic                  sign_p1_d, sign_p1_q;
  logic signed [EW2-1:0] exp_p1_d, exp_p1_q;
  logic [MAN_W:0]        man_a_p1_d, man_a_p1_q, man_b_p1_d, man_b_p1_q;
  cls_e                  cls_p1_d, cls_p1_q;

  logic                  vld_p2_d, vld_p2_q;
  logic                  sign_p2_d, sign_p2_q;
  logic signed [EW2-1:0] exp_p2_d, exp_p2_q;
  logic [PW-1:0]         prod_p2_d, prod_p2_q;
  cls_e                  cls_p2_d, cls_p2_q;

  logic [PW-1:0]         norm;
  logic signed [EW2-1:0] exp_n, exp_r;
  logic [MAN_W-1:0]      frac_n;
  logic                  guard, sticky;
  logic [MAN_W:0]        rnd;

  logic                  out_valid_d, out_valid_q;
  logic [W-1:0]          vres_d, vres_q;

  // Global stall: every stage moves only when the output slot is free or being drained.
  assign advance  = !out_valid_q | out_ready;
  assign in_ready = advance;

  // Stage 1: unpack, classify, sign and biased exponent sum.
  always_comb begin
    exp_a  = v1[W-2 -: EXP_W];
    exp_b  = v2[W-2 -: EXP_W];
    frac_a = v1[MAN_W-1:0];
    frac_b = v2[MAN_W-1:0];
    a_zero = (exp_a == '0);
    b_zero = (exp_b == '0);
    a_inf  = (exp_a == '1) && (frac_a == '0);
    b_inf  = (exp_b == '1) && (frac_b == '0);
    a_nan  = (exp_a == '1) && (frac_a != '0);
    b_nan  = (exp_b == '1) && (frac_b != '0);

    cls_p1_d = CLS_NORM;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) cls_p1_d = CLS_NAN;
    else if (a_inf || b_inf)                                      cls_p1_d = CLS_INF;
    else if (a_zero || b_zero)                                    cls_p1_d = CLS_ZERO;

    vld_p1_d   = in_valid;
    sign_p1_d  = v1[W-1] ^ v2[W-1];
    exp_p1_d   = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_X;
    man_a_p1_d = {1'b1, frac_a};
    man_b_p1_d = {1'b1, frac_b};
  end

  // Stage 2: full-width mantissa product.
  always_comb begin
    vld_p2_d  = vld_p1_q;
    sign_p2_d = sign_p1_q;
    exp_p2_d  = exp_p1_q;
    cls_p2_d  = cls_p1_q;
    prod_p2_d = PW'(man_a_p1_q) * PW'(man_b_p1_q);
  end

  // Stage 3: normalise, round to nearest even, clamp range and pack.
  always_comb begin
    norm        = prod_p2_q[PW-1] ? prod_p2_q : (prod_p2_q << 1);
    exp_n       = exp_p2_q + $signed({{(EW2-1){1'b0}}, prod_p2_q[PW-1]});
    frac_n      = norm[PW-2 -: MAN_W];
    guard       = norm[MAN_W];
    sticky      = |norm[MAN_W-1:0];
    rnd         = rne_round(frac_n, guard, sticky);
    exp_r       = exp_n + $signed({{(EW2-1){1'b0}}, rnd[MAN_W]});
    vres_d      = pack_result(cls_p2_q, sign_p2_q, exp_r, rnd[MAN_W-1:0]);
    out_valid_d = vld_p2_q;
  end

  // Control and result registers: cleared by reset, frozen while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      out_valid_q <= 1'b0;
      vres_q      <= '0;
    end else if (advance) begin
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      out_valid_q <= out_valid_d;
      vres_q      <= vres_d;
    end
  end

  // Internal datapath registers: qualified by the valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    if (advance) begin
      sign_p1_q  <= sign_p1_d;
      exp_p1_q   <= exp_p1_d;
      man_a_p1_q <= man_a_p1_d;
      man_b_p1_q <= man_b_p1_d;
      cls_p1_q   <= cls_p1_d;
      sign_p2_q  <= sign_p2_d;
      exp_p2_q   <= exp_p2_d;
      prod_p2_q  <= prod_p2_d;
      cls_p2_q   <= cls_p2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign vres      = vres_q;

`ifdef FLOAT_MUL_FLAGS_EN
  logic       ovf, unf, is_norm;
  logic [4:0] flags_d, flags_q;

  // Exception flags {invalid, overflow, underflow, inexact, zero} for the stage-3 result.
  always_comb begin
    is_norm = (cls_p2_q == CLS_NORM);
    ovf     = is_norm && (exp_r >= EMAX_X);
    unf     = is_norm && (exp_r <= ZERO_X);
    flags_d = {cls_p2_q == CLS_NAN, ovf, unf,
               is_norm && (guard | sticky | ovf | unf),
               vres_d[W-2:0] == '0};
  end

  // Flags travel with vres under the same reset and stall rules.
  always_ff @(posedge clk) begin
    if (!rst_n)       flags_q <= '0;
    else if (advance) flags_q <= flags_d;
  end

  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_float_mul_pipe.sv
// Testbench for float_mul_pipe: single-precision instance with scoreboard
// against an arithmetic reference model, plus a half-precision instance.
module tb_float_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] v1, v2, vres;
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_v1, h_v2, h_vres;
`ifdef FLOAT_MUL_FLAGS_EN
  logic [4:0]  flags, h_flags;
`endif

  float_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .v1(v1), .v2(v2), .out_valid(out_valid), .out_ready(out_ready),
`ifdef FLOAT_MUL_FLAGS_EN
    .flags(flags),
`endif
    .vres(vres)
  );

  float_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .v1(h_v1), .v2(h_v2), .out_valid(h_out_valid), .out_ready(h_out_ready),
`ifdef FLOAT_MUL_FLAGS_EN
    .flags(h_flags),
`endif
    .vres(h_vres)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  typedef struct packed {logic [4:0] f; logic [31:0] w;} exp_t;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference: exact integer product of the significands, then generic RNE on the
  // discarded bits, then range clamping. Returns {flags, word}.
  function automatic logic [36:0] model_mul(input int ew, input int mw,
                                            input logic [31:0] a, input logic [31:0] b);
    int emx, bias, ea, eb, fa, fb, s, e, k, d;
    longint p, q, rem, half;
    logic an, bn, ai, bi, az, bz;
    logic [31:0] w;
    logic [4:0]  f;
    emx  = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    ea   = int'(a >> mw) & emx;
    eb   = int'(b >> mw) & emx;
    fa   = int'(a) & ((1 << mw) - 1);
    fb   = int'(b) & ((1 << mw) - 1);
    s    = (int'(a >> (ew + mw)) & 1) ^ (int'(b >> (ew + mw)) & 1);
    an = (ea == emx) && (fa != 0);  bn = (eb == emx) && (fb != 0);
    ai = (ea == emx) && (fa == 0);  bi = (eb == emx) && (fb == 0);
    az = (ea == 0);                 bz = (eb == 0);
    f = '0;
    w = '0;
    if (an || bn || (ai && bz) || (az && bi)) begin
      w = (emx << mw) | (1 << (mw - 1));
      f[4] = 1'b1;
    end else if (ai || bi) begin
      w = (s << (ew + mw)) | (emx << mw);
    end else if (az || bz) begin
      w = s << (ew + mw);
    end else begin
      p = longint'((1 << mw) | fa) * longint'((1 << mw) | fb);
      k = 0;
      for (int i = 0; i < 64; i++) if (((p >> i) & 1) != 0) k = i;
      d    = k - mw;
      q    = p >> d;
      rem  = p - (q << d);
      half = longint'(1) << (d - 1);
      e    = ea + eb - bias + (k - 2 * mw);
      if (rem > half || (rem == half && (q & 1) == 1)) q = q + 1;
      if (q == (longint'(1) << (mw + 1))) begin
        q = q >> 1;
        e = e + 1;
      end
      f[1] = (rem != 0);
      if (e >= emx) begin
        w = (s << (ew + mw)) | (emx << mw);
        f[3] = 1'b1; f[1] = 1'b1;
      end else if (e <= 0) begin
        w = s << (ew + mw);
        f[2] = 1'b1; f[1] = 1'b1;
      end else begin
        w = (s << (ew + mw)) | (e << mw) | (int'(q) & ((1 << mw) - 1));
      end
    end
    f[0] = ((w << (32 - (ew + mw))) == 0);
    return {f, w};
  endfunction

  // Compare process: handshake relation, stall stability, in-order results.
  initial begin
    logic        hold_vld;
    logic [31:0] hold_w;
    exp_t        e;
    hold_vld = 1'b0;
    hold_w   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sbq.delete();
        hold_vld = 1'b0;
      end else begin
        chk("in_ready_rel", 32'(in_ready), 32'(!out_valid || out_ready));
        if (hold_vld) begin
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_vres", vres, hold_w);
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (sbq.size() == 0) begin
            chk("unexpected_out", 32'(out_valid), 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("sb_vres", vres, e.w);
`ifdef FLOAT_MUL_FLAGS_EN
            chk("sb_flags", 32'(flags), 32'(e.f));
`endif
          end
        end
        hold_vld = out_valid && !out_ready;
        hold_w   = vres;
        if (in_valid && in_ready) sbq.push_back(exp_t'(model_mul(8, 23, v1, v2)));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic wait_ready();
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic stream_op(input logic [31:0] a, input logic [31:0] b);
    v1 = a; v2 = b; in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    stream_op(a, b);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int g = 0;
    while (!out_valid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 20) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((sbq.size() != 0 || out_valid) && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) chk("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  task automatic half_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] req);
    logic [36:0] r;
    int g = 0;
    r = model_mul(5, 10, {16'd0, a}, {16'd0, b});
    chk("half_model", {16'd0, r[15:0]}, {16'd0, req});
    h_v1 = a; h_v2 = b; h_in_valid = 1'b1;
    @(posedge clk); #1;
    h_in_valid = 1'b0;
    while (!h_out_valid && g < 10) begin
      @(posedge clk); #1;
      g++;
    end
    chk("half_vres", {16'd0, h_vres}, {16'd0, req});
    @(posedge clk); #1;
  endtask

  logic [31:0] ta[10] = '{32'h40E80000, 32'hC0000000, 32'h3F800001, 32'h7F800000, 32'h7F7FFFFF,
                          32'h00800000, 32'h3F800001, 32'h3F800003, 32'h80000000, 32'h00400000};
  logic [31:0] tb[10] = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h00000000, 32'h40000000,
                          32'h3F000000, 32'h3FC00000, 32'h3FC00000, 32'h3F800000, 32'h40000000};
  logic [31:0] tw[10] = '{32'h41680000, 32'hC0C00000, 32'h3F800002, 32'h7FC00000, 32'h7F800000,
                          32'h00000000, 32'h3FC00002, 32'h3FC00004, 32'h80000000, 32'h00000000};
  logic [4:0]  tf[10] = '{5'b00000, 5'b00000, 5'b00010, 5'b10000, 5'b01010,
                          5'b00111, 5'b00010, 5'b00010, 5'b00001, 5'b00001};
  logic [31:0] sa[8]  = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h41200000,
                          32'hC1100000, 32'h3F8CCCCD, 32'h42C80000, 32'h3EAAAAAB};
  logic [31:0] sb[8]  = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h3DCCCCCD,
                          32'h40A00000, 32'h3F8CCCCD, 32'hC2C80000, 32'h40400000};

  initial begin
    logic [36:0] r;
    int n0, cnt;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; v1 = '0; v2 = '0;
    h_in_valid = 1'b0; h_out_ready = 1'b1; h_v1 = '0; h_v2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_vres", vres, 32'd0);
    chk("reset_h_out_valid", 32'(h_out_valid), 32'd0);
`ifdef FLOAT_MUL_FLAGS_EN
    chk("reset_flags", 32'(flags), 32'd0);
`endif
    rst_n = 1'b1;

    // Pin the reference model to hand-computed results.
    for (int i = 0; i < 10; i++) begin
      r = model_mul(8, 23, ta[i], tb[i]);
      chk($sformatf("model_vres_%0d", i), r[31:0], tw[i]);
      chk($sformatf("model_flags_%0d", i), 32'(r[36:32]), 32'(tf[i]));
    end

    // Exact latency: output appears three cycles after the accepting cycle.
    @(posedge clk); #1;
    issue(32'h40E80000, 32'h40000000);
    chk("lat_cycle1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_cycle2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_cycle3", 32'(out_valid), 32'd1);
    chk("lat_vres", vres, 32'h41680000);
    @(posedge clk); #1;
    wait_idle();

    // Directed vectors with literal expectations.
    for (int i = 0; i < 10; i++) begin
      issue(ta[i], tb[i]);
      wait_out();
      chk($sformatf("dir_vres_%0d", i), vres, tw[i]);
`ifdef FLOAT_MUL_FLAGS_EN
      chk($sformatf("dir_flags_%0d", i), 32'(flags), 32'(tf[i]));
`endif
      @(posedge clk); #1;
    end
    wait_idle();

    // Back-to-back stream with the consumer stalling in cycles 2-5.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) stream_op(sa[i], sb[i]);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 14; c++) begin
          out_ready = !(c >= 2 && c <= 5);
          if (c == 4) begin
            @(negedge clk);
            chk("stall_in_ready_low", 32'(in_ready), 32'd0);
            chk("stall_out_valid_high", 32'(out_valid), 32'd1);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();
    chk("stream_count", 32'(n_out - n0), 32'd8);

    // Reset with two operations in flight.
    stream_op(32'h40000000, 32'h40000000);
    stream_op(32'h40400000, 32'h40400000);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_flush_out_valid", 32'(out_valid), 32'd0);
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("rst_no_stale", 32'(cnt), 32'd0);
    issue(32'h40000000, 32'h40400000);
    wait_out();
    chk("rst_recover_vres", vres, 32'h40C00000);
    @(posedge clk); #1;
    wait_idle();

    // Half precision instance.
    half_op(16'h3C00, 16'h4000, 16'h4000);
    half_op(16'h7BFF, 16'h4000, 16'h7C00);
    half_op(16'hC200, 16'h3800, 16'hBE00);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
